// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core's DM port: doubleword array,
// configurable read latency via a stall handshake, sticky fault logging.
module dmem_responder #(
  parameter int N            = 64,
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_stall,
  output logic         fault,
  output logic [1:0]   fault_code,
  output logic [N-1:0] fault_addr
);

  localparam int IW = $clog2(DEPTH);
  // The first BUSY cycle already counts toward the latency, hence L-2.
  localparam logic [2:0] CNT_INIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       r_state, w_nextState;
  logic [2:0]   r_cnt, w_nextCnt;
  logic [N-1:0] r_mem [DEPTH];
  logic         r_fault;
  logic [1:0]   r_faultCode;
  logic [N-1:0] r_faultAddr;

  logic [IW-1:0] w_index;
  logic          w_aligned;
  logic          w_bothEn;
  logic          w_anyEn;
  logic          w_stall;
  logic [N-1:0]  w_rdData;
  logic          w_doWrite;
  logic          w_reject;
  logic          w_unusedAddrBits;

  assign w_index          = DM_addr[IW+2:3];
  assign w_aligned        = (DM_addr[2:0] == 3'b000);
  assign w_bothEn         = DM_writeEnable & DM_readEnable;
  assign w_anyEn          = DM_writeEnable | DM_readEnable;
  assign w_unusedAddrBits = ^DM_addr[N-1:IW+3];

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_stall     = 1'b0;
    w_rdData    = '0;
    w_doWrite   = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyEn && (!w_aligned || w_bothEn)) begin
          w_reject = 1'b1;
        end else if (DM_writeEnable) begin
          w_doWrite = 1'b1;
        end else if (DM_readEnable) begin
          if (READ_LATENCY == 1) begin
            w_rdData = r_mem[w_index];
          end else begin
            w_stall     = 1'b1;
            w_nextState = BUSY;
            w_nextCnt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        // A dropped read enable while busy is a pipeline flush, not an error.
        if (!DM_readEnable) begin
          w_nextState = IDLE;
        end else if (r_cnt != 3'd0) begin
          w_stall   = 1'b1;
          w_nextCnt = r_cnt - 3'd1;
        end else begin
          w_rdData    = r_mem[w_index];
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (reset) begin
      w_stall  = 1'b0;
      w_rdData = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_fault     <= 1'b0;
      r_faultCode <= 2'b00;
      r_faultAddr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_doWrite) begin
        r_mem[w_index] <= DM_writeData;
      end
      if (w_reject && !r_fault) begin
        r_fault     <= 1'b1;
        r_faultCode <= w_aligned ? 2'b10 : 2'b01;
        r_faultAddr <= DM_addr;
      end
    end
  end

  assign DM_stall    = w_stall;
  assign DM_readData = w_rdData;
  assign fault       = r_fault;
  assign fault_code  = r_faultCode;
  assign fault_addr  = r_faultAddr;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the 64-bit pipelined core's DM port, servicing the core's DM_addr/DM_writeData/DM_writeEnable/DM_readEnable requests. Returns DM_readData. Models a configurable read latency through a stall handshake. Writes are single-cycle. Misaligned and illegal requests are detected and logged in a sticky fault register. It sits outside the datapath, in place of the ideal single-cycle data memory.

Parameters:
N, 64, data/address width in bits
DEPTH, 64, number of N-bit doublewords in the array (power of 2)
READ_LATENCY, 2, cycles from read request to valid data (legal 1..8)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
DM_addr  input  N  byte address of the access
DM_writeData  input  N  store data
DM_writeEnable  input  1  store request
DM_readEnable  input  1  load request
DM_readData  output  N  load data; valid only in the completion cycle
DM_stall  output  1  high while a load is in progress and its data is not yet valid
fault  output  1  sticky: some request was rejected
fault_code  output  2  cause of the first rejection: 01 misaligned, 10 read+write together
fault_addr  output  N  DM_addr of the first rejected request

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE and the counter to 0.
  - All array entries are cleared to 0.
  - fault=0, fault_code=00, fault_addr=0.
  - While reset is high, DM_stall=0 and DM_readData=0.
  - Reset asserted mid-load aborts the load. No data is returned.
- Indexing:
  - index = DM_addr[log2(DEPTH)+2:3].
  - Higher address bits are ignored, so addresses wrap modulo DEPTH*8.
- Request classification (evaluated in IDLE):
  - Aligned means DM_addr[2:0]==0.
  - Valid write: writeEnable & ~readEnable & aligned.
  - Valid read: readEnable & ~writeEnable & aligned.
  - Rejected: any enable with a misaligned address, or both enables high. Nothing is performed: no array write, no stall, DM_readData=0.
  - On a rejection, if fault==0: set fault=1 and latch fault_code/fault_addr at the next edge. Later rejections leave all three unchanged. Misalignment takes precedence in the code when both causes apply.
- Write:
  - Committed to the array at the edge ending the request cycle.
  - Never stalls. Takes one cycle.
  - Writes are not accepted in BUSY, because the requester holds the load request while stalled.
- Read, FSM states IDLE and BUSY, with a down-counter cnt of width log2(8):
  - READ_LATENCY==1: no stall. DM_readData = array[index] combinationally in the request cycle. FSM stays in IDLE.
  - READ_LATENCY=L>1, cycle 0 (IDLE, valid read): DM_stall=1 (combinational from request and state). Next state BUSY with cnt=L-2.
  - In BUSY with cnt!=0: DM_stall=1, cnt decrements.
  - In BUSY with cnt==0: DM_stall=0 and DM_readData = array[index] of the held address. Next state IDLE.
  - Result: stall is high for exactly L-1 cycles and data is valid in cycle L-1.
  - The requester must hold DM_addr/DM_readEnable stable while DM_stall=1.
- Abort:
  - Applies when DM_readEnable drops while in BUSY (pipeline flush).
  - DM_stall=0 that same cycle, DM_readData=0, next state IDLE.
  - No fault is raised.
- Back-to-back requests: a new request is first sampled in the IDLE cycle after completion, so consecutive loads each incur the full latency.
- Idle output: DM_readData=0 in every cycle that is not a read completion.

Test Plan:
- Reset, then read addr 0x0 with L=2 → DM_stall=1 for 1 cycle, then 0 with DM_readData=0; fault=0.
- Write 0xDEADBEEFCAFEF00D @0x18, then read 0x18 with L=3 → DM_stall high for cycles 0–1, low in cycle 2 with DM_readData=0xDEADBEEFCAFEF00D. Confirm the write produced no stall.
- DEPTH=64: write 5 @0x200, read @0x0 → 5 (wrap-around); write 7 @0x1F8, read @0x3F8 → 7.
- Write @0x1C → array unchanged (read 0x18 and 0x20 return prior values), fault=1, code=01, addr=0x1C. Then a simultaneous read+write @0x40 → no write; fault_code/fault_addr stay 01/0x1C.
- L=4 read @0x8, drop readEnable in cycle 1 → DM_stall=0 that cycle and FSM back in IDLE the next. A following read @0x10 completes after exactly 4 cycles with correct data.
- Assert reset during BUSY (L=4, cycle 2) → next cycle DM_stall=0, all entries read back 0, fault cleared.
